// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I sequencing FSM with memory-ready stalls and ALU decode
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrSrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q, state_d;
  logic       pcupdate, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, done_raw, illegal_raw;
  logic [1:0] aluop;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    adrSrc       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    resultSrc    = 2'b00;
    aluSrcA      = 2'b00;
    aluSrcB      = 2'b00;
    aluop        = 2'b00;
    case (state_q)
      S_FETCH: begin
        aluSrcB     = 2'b10;
        resultSrc   = 2'b10;
        irwrite_raw = mem_ready;
        pcupdate    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc    = 2'b01;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe held through the stall; retirement only on the accepting cycle
        adrSrc       = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        aluSrcA = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        aluSrcA  = 2'b01;
        aluSrcB  = 2'b10;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BEQ: begin
        aluSrcA  = 2'b10;
        aluop    = 2'b01;
        branch   = 1'b1;
        done_raw = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (aluop)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Enables are masked by reset so nothing can pulse while rst is low
  assign pcwrite    = rst & (pcupdate | (branch & zero));
  assign irwrite    = rst & irwrite_raw;
  assign memwrite   = rst & memwrite_raw;
  assign regwrite   = rst & regwrite_raw;
  assign instr_done = rst & done_raw;
  assign illegal    = rst & illegal_raw;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, adrSrc, memwrite, irwrite, regwrite;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] alu_control;
  logic       instr_done, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrSrc(adrSrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .immSrc(immSrc), .alu_control(alu_control), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  typedef struct {
    int st;
    bit mr, z;
    bit pcw, irw, mw, rw, done, ill;
    int alu, rsrc, imm;
  } cyc_t;

  cyc_t q[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input int st, input bit mr, input bit z);
    cyc_t c;
    c = '{default: 0};
    c.st = st; c.mr = mr; c.z = z;
    c.alu = -1; c.rsrc = -1; c.imm = -1;
    return c;
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000:  return (o == RT && f7[5]) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_imm(input logic [6:0] o);
    if (o == SW) return 1;
    if (o == BQ) return 2;
    if (o == JL) return 3;
    return 0;
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return (o == LW || o == SW || o == RT || o == IA || o == JL || o == BQ);
  endfunction

  // Builds the expected cycle-by-cycle trace of one instruction, then plays it
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int sf, input int sr, input int sw_n, input int bz);
    cyc_t c;
    bit   z;
    q.delete();
    for (int i = 0; i < sf; i++) q.push_back(mk(0, 1'b0, rb()));
    c = mk(0, 1'b1, rb()); c.pcw = 1; c.irw = 1; c.rsrc = 2; q.push_back(c);
    c = mk(1, rb(), rb()); c.imm = exp_imm(o); c.alu = 0; c.ill = !legal(o); q.push_back(c);
    case (o)
      LW: begin
        c = mk(2, rb(), rb()); c.alu = 0; q.push_back(c);
        for (int i = 0; i < sr; i++) q.push_back(mk(3, 1'b0, rb()));
        c = mk(3, 1'b1, rb()); c.rsrc = 0; q.push_back(c);
        c = mk(4, rb(), rb()); c.rw = 1; c.done = 1; c.rsrc = 1; q.push_back(c);
      end
      SW: begin
        c = mk(2, rb(), rb()); c.alu = 0; q.push_back(c);
        for (int i = 0; i < sw_n; i++) begin
          c = mk(5, 1'b0, rb()); c.mw = 1; q.push_back(c);
        end
        c = mk(5, 1'b1, rb()); c.mw = 1; c.done = 1; q.push_back(c);
      end
      RT, IA, JL: begin
        c = mk((o == RT) ? 6 : (o == IA) ? 8 : 9, rb(), rb());
        if (o == JL) begin c.pcw = 1; c.alu = 0; end
        else c.alu = exp_alu(o, f3, f7);
        q.push_back(c);
        c = mk(7, rb(), rb()); c.rw = 1; c.done = 1; c.rsrc = 0; q.push_back(c);
      end
      BQ: begin
        z = (bz < 0) ? rb() : bit'(bz);
        c = mk(10, rb(), z); c.pcw = z; c.done = 1; c.alu = 1; q.push_back(c);
      end
      default: ;
    endcase
    op = o; funct3 = f3; funct7 = f7;
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      zero = q[i].z;
      @(negedge clk);
      chk($sformatf("op%b c%0d state", o, i), 32'(state), q[i].st);
      chk($sformatf("op%b c%0d pcwrite", o, i), 32'(pcwrite), 32'(q[i].pcw));
      chk($sformatf("op%b c%0d irwrite", o, i), 32'(irwrite), 32'(q[i].irw));
      chk($sformatf("op%b c%0d memwrite", o, i), 32'(memwrite), 32'(q[i].mw));
      chk($sformatf("op%b c%0d regwrite", o, i), 32'(regwrite), 32'(q[i].rw));
      chk($sformatf("op%b c%0d instr_done", o, i), 32'(instr_done), 32'(q[i].done));
      chk($sformatf("op%b c%0d illegal", o, i), 32'(illegal), 32'(q[i].ill));
      if (q[i].alu >= 0)  chk($sformatf("op%b c%0d alu_control", o, i), 32'(alu_control), q[i].alu);
      if (q[i].rsrc >= 0) chk($sformatf("op%b c%0d resultSrc", o, i), 32'(resultSrc), q[i].rsrc);
      if (q[i].imm >= 0)  chk($sformatf("op%b c%0d immSrc", o, i), 32'(immSrc), q[i].imm);
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] op_tab [0:8];

  initial begin
    op_tab[0] = LW; op_tab[1] = SW; op_tab[2] = RT; op_tab[3] = IA; op_tab[4] = JL;
    op_tab[5] = BQ; op_tab[6] = 7'b1110011; op_tab[7] = 7'b0000000; op_tab[8] = 7'b0110111;

    rst = 1'b0; op = RT; funct3 = 3'b000; funct7 = 7'b0000000; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("reset state", 32'(state), 0);
    chk("reset irwrite", 32'(irwrite), 0);
    chk("reset pcwrite", 32'(pcwrite), 0);
    chk("reset aluSrcB", 32'(aluSrcB), 2);
    chk("reset adrSrc", 32'(adrSrc), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post-reset decode", 32'(state), 1);
    @(posedge clk); #1;
    chk("reach executer", 32'(state), 6);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset state", 32'(state), 0);
    chk("async reset pcwrite", 32'(pcwrite), 0);
    chk("async reset irwrite", 32'(irwrite), 0);
    chk("async reset memwrite", 32'(memwrite), 0);
    chk("async reset regwrite", 32'(regwrite), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release to decode", 32'(state), 1);
    rst = 1'b0;
    #1;
    rst = 1'b1;

    run_instr(LW, 3'b010, 7'h00, 0, 0, 0, -1);
    run_instr(SW, 3'b010, 7'h00, 0, 0, 2, -1);
    run_instr(RT, 3'b000, 7'b0100000, 0, 0, 0, -1);
    run_instr(RT, 3'b000, 7'b0000000, 0, 0, 0, -1);
    run_instr(RT, 3'b111, 7'b0000000, 0, 0, 0, -1);
    run_instr(IA, 3'b000, 7'b0100000, 0, 0, 0, -1);
    run_instr(BQ, 3'b000, 7'h00, 0, 0, 0, 1);
    run_instr(BQ, 3'b000, 7'h00, 0, 0, 0, 0);
    run_instr(7'b1110011, 3'b000, 7'h00, 0, 0, 0, -1);
    run_instr(JL, 3'b000, 7'h00, 2, 0, 0, -1);
    run_instr(LW, 3'b010, 7'h00, 1, 3, 0, -1);

    for (int n = 0; n < 80; n++) begin
      run_instr(op_tab[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RV32I core: a Moore FSM that walks each instruction through fetch, decode, execute, memory and writeback. It drives every enable and mux select of the shared datapath, which has one memory, one ALU and one register file. It also contains the ALU-op to ALU-control decode. It replaces the single-cycle control unit when the core runs in multicycle mode, and adds a memory ready handshake so instruction and data accesses can stall.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0], taken from the instruction register
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite  out  1  PC register enable
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction and OldPC register enable
- regwrite  out  1  register file write enable
- resultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- aluSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 reg
- aluSrcB  out  2  ALU B select: 00 = rs2 reg, 01 = ImmExt, 10 = const 4
- immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  out  4  current state, for debug and verification

## Operation
- State register: 4 bits, updated on the clk rising edge. The async clear sets it to FETCH (0).
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11–15 go to FETCH on the next edge, with all enables at 0.
- Transitions:
  - FETCH → DECODE when mem_ready = 1; otherwise hold in FETCH.
  - DECODE, by op:
    - lw 0000011 or sw 0100011 → MEMADR
    - R-type 0110011 → EXECUTER
    - I-ALU 0010011 → EXECUTEI
    - jal 1101111 → JAL
    - beq 1100011 → BEQ
    - any other op → FETCH, with illegal = 1
  - MEMADR → MEMREAD if op = lw, MEMWRITE if op = sw.
  - MEMREAD → MEMWB when mem_ready = 1; otherwise hold.
  - MEMWRITE → FETCH when mem_ready = 1; otherwise hold.
  - MEMWB → FETCH; EXECUTER → ALUWB; EXECUTEI → ALUWB; ALUWB → FETCH; JAL → ALUWB; BEQ → FETCH.
- Outputs are Moore outputs (from state), except where gated by mem_ready or zero. Any field not listed below is 0.
  - FETCH: adrSrc=0; aluSrcA=00; aluSrcB=10; aluop=00; resultSrc=10; irwrite=mem_ready; pcupdate=mem_ready.
  - DECODE: aluSrcA=01; aluSrcB=01; aluop=00. This computes the branch target.
  - MEMADR: aluSrcA=10; aluSrcB=01; aluop=00.
  - MEMREAD: adrSrc=1; resultSrc=00.
  - MEMWB: resultSrc=01; regwrite=1.
  - MEMWRITE: adrSrc=1; resultSrc=00; memwrite=1. memwrite stays high every cycle until mem_ready.
  - EXECUTER: aluSrcA=10; aluSrcB=00; aluop=10.
  - EXECUTEI: aluSrcA=10; aluSrcB=01; aluop=10.
  - ALUWB: resultSrc=00; regwrite=1.
  - JAL: aluSrcA=01; aluSrcB=10; aluop=00; resultSrc=00; pcupdate=1.
  - BEQ: aluSrcA=10; aluSrcB=00; aluop=01; resultSrc=00; branch=1.
- pcwrite = pcupdate | (branch & zero).
- immSrc is decoded from op in every state: lw and I-ALU → 00, sw → 01, beq → 10, jal → 11, others → 00.
- ALU decode:
  - aluop 00 → add; aluop 01 → sub; aluop 11 → add.
  - aluop 10, by funct3:
    - 000 → sub if op[5] & funct7[5], else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other funct3 → add
- instr_done = 1 in exactly these cases: MEMWB; ALUWB; BEQ; MEMWRITE when mem_ready = 1.

## Timing
- Reset: while rst = 0, state = FETCH and pcwrite, irwrite, memwrite, regwrite, instr_done and illegal are all forced to 0. Mux selects take their FETCH values.
- Reset deassertion: the first edge with rst = 1 evaluates FETCH normally.
- Reset mid-instruction: any state returns to FETCH immediately (asynchronous). No write enable may glitch high during the reset.
- Cycle counts with mem_ready tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - I-ALU: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- Stalls: each cycle with mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle. During a stall, only memwrite (in MEMWRITE) remains asserted; all other enables stay at 0.
- beq: zero is sampled combinationally in the BEQ cycle. pcwrite follows zero within that same cycle.

## Test plan
- Reset: rst = 0 asserted mid-EXECUTER → state = 0 asynchronously, with pcwrite, irwrite, memwrite, regwrite = 0. After release with mem_ready = 1, the next edge gives state = 1.
- lw, mem_ready = 1: op = 0000011 → state sequence 0,1,2,3,4,0. regwrite = 1 and resultSrc = 01 only in state 4. instr_done pulses once.
- sw with a 2-cycle memory stall: mem_ready = 0 for 2 cycles in MEMWRITE → memwrite = 1 for 3 cycles, state holds at 5, then returns to 0.
- R-type: op = 0110011, funct3 = 000, funct7 = 0100000 → alu_control = 001 in EXECUTER. With funct7 = 0 → 000. With funct3 = 111 → 010.
- beq: zero = 1 → pcwrite = 1 in BEQ and alu_control = 001. With zero = 0 → pcwrite = 0. Both cases take 3 cycles and pulse instr_done.
- Illegal opcode 1110011 → illegal = 1 for one cycle in DECODE, next state = 0, no regwrite or memwrite asserted.
